// File: rtl/traffic_ctrl_param_if.sv
// traffic_ctrl_param_if: control inputs and light/countdown outputs of the traffic controller
interface traffic_ctrl_param_if;
    logic       tick;
    logic       stopa;
    logic       stopb;
    logic       pause;
    logic       req_b;
    logic [2:0] light_a;
    logic [2:0] light_b;
    logic [7:0] time_a;
    logic [7:0] time_b;
    logic [2:0] phase;
    modport master (output tick, stopa, stopb, pause, req_b,
                    input  light_a, light_b, time_a, time_b, phase);
    modport slave  (input  tick, stopa, stopb, pause, req_b,
                    output light_a, light_b, time_a, time_b, phase);
endinterface

// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: tick-driven two-direction light controller with demand-actuated B green.
// Define TRAFFIC_ALLRED_EN to insert the CLR1/CLR2 all-red clearance phases.
module traffic_ctrl_param #(
    parameter int GREEN_A = 25,
    parameter int GREEN_B = 20,
    parameter int YELLOW  = 5,
    parameter int ALLRED  = 2
) (
    input logic clk,
    input logic rst,
    traffic_ctrl_param_if.slave bus
);
    typedef enum logic [2:0] {INIT, A_GRN, A_YEL, CLR1, B_GRN, B_YEL, CLR2, FORCE} state_t;

    localparam int GMAX = (GREEN_A > GREEN_B) ? GREEN_A : GREEN_B;
    localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;

    if (GREEN_A < 1 || GREEN_A > 99 || GREEN_B < 1 || GREEN_B > 99 ||
        YELLOW < 1 || YELLOW > 99 || ALLRED < 1 || ALLRED > 99 ||
        2 * ALLRED + GMAX + YELLOW > 99) begin : g_bad_param
        $error("traffic_ctrl_param: timing parameters out of range");
    end

`ifdef TRAFFIC_ALLRED_EN
    localparam int AR = ALLRED;
    localparam state_t AY_NEXT = CLR1, BY_NEXT = CLR2, REL_S = CLR2;
    localparam logic [6:0] AY_CNT = 7'(ALLRED), BY_CNT = 7'(ALLRED), REL_C = 7'(ALLRED);
`else
    localparam int AR = 0;
    localparam state_t AY_NEXT = B_GRN, BY_NEXT = A_GRN, REL_S = A_GRN;
    localparam logic [6:0] AY_CNT = 7'(GREEN_B), BY_CNT = 7'(GREEN_A), REL_C = 7'(GREEN_A);
`endif

    function automatic logic [7:0] to_bcd(input int v);
        int s;
        s = (v > 99) ? 99 : v;
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    state_t     state, ns;
    logic [6:0] cnt, nc;
    logic [2:0] nla, nlb;
    int         sa, sb;

    always_comb begin
        ns = state;
        nc = cnt;
        if (bus.stopa || bus.stopb) begin
            ns = FORCE;
            nc = '0;
        end else if (state == FORCE) begin
            ns = REL_S;
            nc = REL_C;
        end else if (!bus.pause && bus.tick) begin
            if (state == INIT) begin
                ns = A_GRN;
                nc = 7'(GREEN_A);
            end else if (cnt > 7'd1) begin
                nc = cnt - 7'd1;
            end else if (!(state == A_GRN && !bus.req_b)) begin
                // cnt == 1: phase expires; A_GRN only yields once B has demand
                case (state)
                    A_GRN:   begin ns = A_YEL;   nc = 7'(YELLOW);  end
                    A_YEL:   begin ns = AY_NEXT; nc = AY_CNT;      end
                    CLR1:    begin ns = B_GRN;   nc = 7'(GREEN_B); end
                    B_GRN:   begin ns = B_YEL;   nc = 7'(YELLOW);  end
                    B_YEL:   begin ns = BY_NEXT; nc = BY_CNT;      end
                    CLR2:    begin ns = A_GRN;   nc = 7'(GREEN_A); end
                    default: begin ns = state;   nc = cnt;         end
                endcase
            end
        end
    end

    always_comb begin
        sa  = int'(nc);
        sb  = int'(nc);
        nla = LR;
        nlb = LR;
        case (ns)
            A_GRN: begin nla = LG; sb = int'(nc) + YELLOW + AR; end
            A_YEL: begin nla = LY; sb = int'(nc) + AR; end
            CLR1:  sa = int'(nc) + GREEN_B + YELLOW + AR;
            B_GRN: begin nlb = LG; sa = int'(nc) + YELLOW + AR; end
            B_YEL: begin nlb = LY; sa = int'(nc) + AR; end
            CLR2:  sb = int'(nc) + GREEN_A + YELLOW + AR;
            FORCE: begin nla = bus.stopa ? LR : LG; nlb = bus.stopa ? LG : LR; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            cnt         <= '0;
            bus.light_a <= LR;
            bus.light_b <= LR;
            bus.time_a  <= 8'hFF;
            bus.time_b  <= 8'hFF;
            bus.phase   <= INIT;
        end else begin
            state       <= ns;
            cnt         <= nc;
            bus.light_a <= nla;
            bus.light_b <= nlb;
            bus.time_a  <= (ns == INIT || ns == FORCE) ? 8'hFF : to_bcd(sa);
            bus.time_b  <= (ns == INIT || ns == FORCE) ? 8'hFF : to_bcd(sb);
            bus.phase   <= ns;
        end
    end
endmodule

// File: tb/tb_traffic_ctrl_param.sv
// tb_traffic_ctrl_param: table-driven check of the controller with GREEN_A=3, GREEN_B=2, YELLOW=1, ALLRED=1.
module tb_traffic_ctrl_param;
    localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;

    typedef struct {
        logic       tick, req_b, stopa, stopb, pause;
        logic [2:0] la, lb;
        logic [7:0] ta, tb;
        logic [2:0] ph;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass = 0;
    int   total = 0;
    vec_t q[$];

    traffic_ctrl_param_if bus();
    traffic_ctrl_param #(.GREEN_A(3), .GREEN_B(2), .YELLOW(1), .ALLRED(1)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic add(input logic t, r, sa, sb, p, input logic [2:0] la, lb,
                       input logic [7:0] ta, tb, input logic [2:0] ph);
        q.push_back('{t, r, sa, sb, p, la, lb, ta, tb, ph});
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass++;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] la, lb, input logic [7:0] ta, tb,
                           input logic [2:0] ph);
        chk({tag, " light_a"}, {5'd0, bus.light_a}, {5'd0, la});
        chk({tag, " light_b"}, {5'd0, bus.light_b}, {5'd0, lb});
        chk({tag, " time_a"}, bus.time_a, ta);
        chk({tag, " time_b"}, bus.time_b, tb);
        chk({tag, " phase"}, {5'd0, bus.phase}, {5'd0, ph});
    endtask

    task automatic drive(input logic t, r, sa, sb, p);
        @(negedge clk);
        bus.tick  = t;
        bus.req_b = r;
        bus.stopa = sa;
        bus.stopb = sb;
        bus.pause = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.tick = 0; bus.req_b = 0; bus.stopa = 0; bus.stopb = 0; bus.pause = 0;
`ifdef TRAFFIC_ALLRED_EN
        add(1,1,0,0,0, LG,LR, 8'h03,8'h05, 1);
        add(0,1,0,0,0, LG,LR, 8'h03,8'h05, 1);
        add(1,1,0,0,0, LG,LR, 8'h02,8'h04, 1);
        add(1,1,0,0,0, LG,LR, 8'h01,8'h03, 1);
        add(1,1,0,0,0, LY,LR, 8'h01,8'h02, 2);
        add(1,1,0,0,0, LR,LR, 8'h05,8'h01, 3);
        add(1,1,0,0,0, LR,LG, 8'h04,8'h02, 4);
        add(1,1,0,0,0, LR,LG, 8'h03,8'h01, 4);
        add(1,1,0,0,0, LR,LY, 8'h02,8'h01, 5);
        add(1,1,0,0,0, LR,LR, 8'h01,8'h06, 6);
        add(1,1,0,0,0, LG,LR, 8'h03,8'h05, 1);
        add(1,1,0,0,0, LG,LR, 8'h02,8'h04, 1);
        add(1,1,0,0,0, LG,LR, 8'h01,8'h03, 1);
        for (int i = 0; i < 4; i++) add(1,0,0,0,0, LG,LR, 8'h01,8'h03, 1);
        add(1,1,0,0,0, LY,LR, 8'h01,8'h02, 2);
        for (int i = 0; i < 3; i++) add(1,1,0,0,1, LY,LR, 8'h01,8'h02, 2);
        add(1,1,0,0,0, LR,LR, 8'h05,8'h01, 3);
        add(1,1,0,0,0, LR,LG, 8'h04,8'h02, 4);
        add(0,1,1,0,0, LR,LG, 8'hFF,8'hFF, 7);
        add(1,1,1,0,0, LR,LG, 8'hFF,8'hFF, 7);
        add(0,1,0,1,0, LG,LR, 8'hFF,8'hFF, 7);
        add(0,1,0,0,0, LR,LR, 8'h01,8'h06, 6);
        add(1,1,0,0,0, LG,LR, 8'h03,8'h05, 1);
`else
        add(1,1,0,0,0, LG,LR, 8'h03,8'h04, 1);
        add(0,1,0,0,0, LG,LR, 8'h03,8'h04, 1);
        add(1,1,0,0,0, LG,LR, 8'h02,8'h03, 1);
        add(1,1,0,0,0, LG,LR, 8'h01,8'h02, 1);
        add(1,1,0,0,0, LY,LR, 8'h01,8'h01, 2);
        add(1,1,0,0,0, LR,LG, 8'h03,8'h02, 4);
        add(1,1,0,0,0, LR,LG, 8'h02,8'h01, 4);
        add(1,1,0,0,0, LR,LY, 8'h01,8'h01, 5);
        add(1,1,0,0,0, LG,LR, 8'h03,8'h04, 1);
        add(1,1,0,0,0, LG,LR, 8'h02,8'h03, 1);
        add(1,1,0,0,0, LG,LR, 8'h01,8'h02, 1);
        for (int i = 0; i < 4; i++) add(1,0,0,0,0, LG,LR, 8'h01,8'h02, 1);
        add(1,1,0,0,0, LY,LR, 8'h01,8'h01, 2);
        for (int i = 0; i < 3; i++) add(1,1,0,0,1, LY,LR, 8'h01,8'h01, 2);
        add(1,1,0,0,0, LR,LG, 8'h03,8'h02, 4);
        add(0,1,1,0,0, LR,LG, 8'hFF,8'hFF, 7);
        add(1,1,1,0,0, LR,LG, 8'hFF,8'hFF, 7);
        add(0,1,0,1,0, LG,LR, 8'hFF,8'hFF, 7);
        add(0,1,0,0,0, LG,LR, 8'h03,8'h04, 1);
        add(1,1,0,0,0, LG,LR, 8'h02,8'h03, 1);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", LR, LR, 8'hFF, 8'hFF, 0);
        @(negedge clk);
        rst = 0;
        drive(0, 1, 0, 0, 0);
        chk_all("init_idle", LR, LR, 8'hFF, 8'hFF, 0);
        foreach (q[i]) begin
            drive(q[i].tick, q[i].req_b, q[i].stopa, q[i].stopb, q[i].pause);
            chk_all($sformatf("vec%0d", i), q[i].la, q[i].lb, q[i].ta, q[i].tb, q[i].ph);
        end
        // Asynchronous reset mid-phase: outputs must drop before any clock edge
        @(negedge clk);
        bus.tick = 0;
        rst = 1;
        #1;
        chk_all("async_rst", LR, LR, 8'hFF, 8'hFF, 0);
        @(negedge clk);
        rst = 0;
        drive(0, 1, 0, 0, 0);
        chk_all("post_rst_idle", LR, LR, 8'hFF, 8'hFF, 0);
        drive(1, 1, 0, 0, 0);
`ifdef TRAFFIC_ALLRED_EN
        chk_all("post_rst_tick", LG, LR, 8'h03, 8'h05, 1);
`else
        chk_all("post_rst_tick", LG, LR, 8'h03, 8'h04, 1);
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
